// File: rtl/add8_seq_wide_pkg.sv
// Shared definitions for the add8_seq_wide block: chunk width, controller
// states and the counter-width helper.
package add8_seq_wide_pkg;

  localparam int CHUNK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, never less than 1 so a one-chunk counter still has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/add8_seq_wide_slice.sv
// The single 8-bit add-with-carry slice shared across all chunks.
module add8_slice
  import add8_seq_wide_pkg::*;
(
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               c_i,
  output logic [CHUNK_W:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK_W{1'b0}}, c_i};

endmodule

// File: rtl/add8_seq_wide.sv
// Wide adder that walks one 8-bit slice over WORDS chunks, LSB chunk first,
// with valid/ready handshakes on both sides.
module add8_seq_wide
  import add8_seq_wide_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   I_VALID,
  output logic                   I_READY,
  input  logic [CHUNK_W*WORDS-1:0] I0,
  input  logic [CHUNK_W*WORDS-1:0] I1,
  input  logic                   CIN,
  output logic                   O_VALID,
  input  logic                   O_READY,
  output logic [CHUNK_W*WORDS-1:0] O,
  output logic                   COUT,
  output logic                   BUSY
);

  localparam int W     = CHUNK_W * WORDS;
  localparam int CNT_W = clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_e           state_q;
  logic [W-1:0]     a_q, b_q, o_q, res_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q, o_valid_q, busy_q;
  logic [CHUNK_W:0] sum;

  add8_slice u_slice (
    .a_i  (a_q[CHUNK_W-1:0]),
    .b_i  (b_q[CHUNK_W-1:0]),
    .c_i  (carry_q),
    .sum_o(sum)
  );

  // Upper chunks already summed wait here; the final chunk completes res_d.
  if (WORDS > 1) begin : g_acc
    logic [W-CHUNK_W-1:0] res_q;
    assign res_d = {sum[CHUNK_W-1:0], res_q};
    always_ff @(posedge CLK) begin
      if (RESET) res_q <= '0;
      else if (state_q == RUN) res_q <= res_d[W-1:CHUNK_W];
    end
  end else begin : g_single
    assign res_d = sum[CHUNK_W-1:0];
  end

  // NOTE: non-blocking assignments so every register here sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      o_q       <= '0;
      cout_q    <= 1'b0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (I_VALID) begin
            a_q     <= I0;
            b_q     <= I1;
            carry_q <= CIN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK_W;
          b_q     <= b_q >> CHUNK_W;
          carry_q <= sum[CHUNK_W];
          if (cnt_q == LAST) begin
            o_q       <= res_d;
            cout_q    <= sum[CHUNK_W];
            o_valid_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (O_READY) begin
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign I_READY = (state_q == IDLE) && !RESET;
  assign O_VALID = o_valid_q;
  assign O       = o_q;
  assign COUT    = cout_q;
  assign BUSY    = busy_q;

endmodule

// File: doc/add8_seq_wide.md
Name: add8_seq_wide

Overview:
- Multi-cycle wide adder controller that time-shares one 8-bit add-with-carry slice across WORDS byte chunks.
- Computes an (8*WORDS)-bit sum plus carry-in, least-significant chunk first.
- Uses valid/ready handshakes on input and output.
- Sits between operand producers and consumers where area matters more than latency.

Parameters:
- WORDS, 4, number of 8-bit chunks; operand width = 8*WORDS; legal range 1..16.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- I_VALID  input  1  operands present.
- I_READY  output  1  block accepts operands this cycle.
- I0  input  8*WORDS  operand A.
- I1  input  8*WORDS  operand B.
- CIN  input  1  carry-in.
- O_VALID  output  1  result available.
- O_READY  input  1  consumer accepts result.
- O  output  8*WORDS  sum modulo 2^(8*WORDS).
- COUT  output  1  carry-out, bit 8*WORDS of the full sum.
- BUSY  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock, CLK. Reset is RESET, synchronous and active-high: sampled on the CLK rising edge, no asynchronous path.
- Reset values: state=IDLE, chunk counter=0, carry register=0, O=0, COUT=0, O_VALID=0, BUSY=0.
- I_READY is 0 while RESET is high and 1 in IDLE otherwise.
- States: IDLE, RUN, DONE.
  - IDLE: I_READY=1. If I_VALID is high at an edge, capture I0, I1 and CIN into the operand shift registers and carry register. Set counter=0 and go to RUN.
  - RUN: I_READY=0. Each cycle the slice computes {0,a[7:0]} + {0,b[7:0]} + carry as a 9-bit result. The low chunk a[7:0], b[7:0] is the bottom 8 bits of the operand registers.
    - At the edge: sum[7:0] shifts into the top of the result register (result shifts right 8), operands shift right 8, carry<=sum[8], counter++.
    - After the edge processing counter==WORDS-1, go to DONE. O_VALID=1 with COUT=carry.
  - DONE: O and COUT are held stable while O_VALID=1 and O_READY=0. On an edge with O_READY=1, go to IDLE and clear O_VALID. O and COUT keep their last value.
- Latency: acceptance at edge t gives O_VALID high after edge t+WORDS. Throughput is one operation per WORDS+2 cycles minimum.
- No overlap: inputs are not accepted in RUN or DONE. I_VALID and the operand values are ignored there.
- The carry propagates across chunks strictly through the carry register; no combinational path from CIN to COUT.
- Result: O = (I0+I1+CIN) mod 2^(8*WORDS); COUT = floor((I0+I1+CIN) / 2^(8*WORDS)).
- RESET in RUN or DONE aborts the operation. Next cycle: IDLE, O_VALID=0, no partial result emitted, O/COUT cleared to 0.
- RESET has priority over every handshake in the same cycle.
- WORDS=1: RUN lasts exactly one cycle.
- Counter width is clog2(WORDS), minimum 1 bit. No wrap beyond WORDS-1.

Decomposition:
- Shared package holds:
  - CHUNK_W=8.
  - State enum {IDLE, RUN, DONE}.
  - Function clog2 for the counter width.
- One sub-module: add8_slice, a combinational 8-bit add with carry-in and carry-out (9-bit sum). It is the only arithmetic in the block.
- The controller holds the FSM, counter, shift registers and carry register.

Test Plan:
- WORDS=4, I0=0x12345678, I1=0x11111111, CIN=0 -> O=0x23456789, COUT=0. O_VALID rises exactly 4 edges after acceptance.
- I0=0xFFFFFFFF, I1=0x00000000, CIN=1 -> O=0x00000000, COUT=1. The carry ripples through all four chunks.
- I0=0xFFFFFFFF, I1=0xFFFFFFFF, CIN=1 -> O=0xFFFFFFFF, COUT=1.
- Hold O_READY=0 for 3 cycles after O_VALID -> O, COUT and O_VALID stay stable, I_READY=0. O_READY=1 -> next cycle IDLE, I_READY=1.
- Assert RESET during the 2nd RUN cycle -> next cycle O_VALID=0, O=0, I_READY=1. Then 0x00000001+0x00000001, CIN=0 -> O=0x00000002.
- Back-to-back: I_VALID held high with two operand pairs -> second accepted on the first edge after the output handshake, both results correct. Repeat with WORDS=1: 0xFF+0x01, CIN=0 -> O=0x00, COUT=1 after 1 cycle.
